// File: rtl/sifh_zoom_histogrammer.sv
// sifh_zoom_histogrammer: multi-pass coarse-to-fine SiFH histogram builder
// with per-pixel peak detection. Each pass histograms NB bits of timestamp
// resolution inside the window chosen by the previous pass.
// Optional feature macro: SIFH_PEAK_COUNT_EN adds the peak_cnt output.
module sifh_zoom_histogrammer #(
  parameter int NP             = 12,
  parameter int NB             = 4,
  parameter int PASSES         = 3,
  parameter int PIXELS         = 4,
  parameter int DATA_PER_PIXEL = 4,
  parameter int ACQ_NUM        = 8,
  parameter int CNT_W          = 8
) (
  input  logic                                           clk,
  input  logic                                           res,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [NP-1:0]                                  data,
  output logic [((PASSES > 1) ? $clog2(PASSES) : 1)-1:0] pass_idx,
  output logic [NP*PIXELS-1:0]                           result,
  output logic [PIXELS-1:0]                              result_mask,
  output logic                                           result_valid
`ifdef SIFH_PEAK_COUNT_EN
  ,
  output logic [CNT_W*PIXELS-1:0]                        peak_cnt
`endif
);

  localparam int PW    = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int BINS  = 2 ** NB;
  localparam int WORDS = PIXELS * BINS;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int XW    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int DW    = (DATA_PER_PIXEL > 1) ? $clog2(DATA_PER_PIXEL) : 1;
  localparam int QW    = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_UPDATE, S_OUT} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_pass;
  logic [DW-1:0]         r_in_cnt;
  logic [XW-1:0]         r_pix;
  logic [QW-1:0]         r_acq;
  logic                  r_in_ready;
  logic                  r_result_valid;
  logic [NP*PIXELS-1:0]  r_result;
  logic [PIXELS-1:0]     r_result_mask;
  logic [PIXELS-1:0]     r_mask;
  logic [NP-1:0]         r_lo [PIXELS];

  logic [CNT_W-1:0]      r_hist [WORDS];
  logic [WORDS-1:0]      r_bvalid;

  logic                  r_pk_valid;
  logic [XW-1:0]         r_pk_pix;
  logic [NB-1:0]         r_pk_bin;
  logic [CNT_W-1:0]      r_pk_cnt;
  logic [CNT_W-1:0]      r_max [PIXELS];
  logic [NB-1:0]         r_peak [PIXELS];

  logic                  w_accept;
  logic                  w_last_in;
  logic                  w_last_pix;
  logic                  w_last_acq;
  logic                  w_pass_done;
  logic                  w_last_pass;
  logic [NP-1:0]         w_lo_cur;
  logic [NP-1:0]         w_off;
  logic [31:0]           w_win_sh;
  logic [31:0]           w_bin_sh;
  logic                  w_in_win;
  logic [NB-1:0]         w_bin;
  logic [AW-1:0]         w_addr;
  logic [CNT_W-1:0]      w_old_cnt;
  logic [CNT_W-1:0]      w_new_cnt;
  logic [NP-1:0]         w_lo_new [PIXELS];
  logic [PIXELS-1:0]     w_mask_new;
  logic [PIXELS-1:0]     w_has_peak;
  logic [NP*PIXELS-1:0]  w_result_new;

  assign in_ready     = r_in_ready;
  assign pass_idx     = r_pass;
  assign result       = r_result;
  assign result_mask  = r_result_mask;
  assign result_valid = r_result_valid;

  assign w_accept    = in_valid && r_in_ready;
  assign w_last_in   = (r_in_cnt == DW'(DATA_PER_PIXEL - 1));
  assign w_last_pix  = (r_pix == XW'(PIXELS - 1));
  assign w_last_acq  = (r_acq == QW'(ACQ_NUM - 1));
  assign w_pass_done = w_accept && w_last_in && w_last_pix && w_last_acq;
  assign w_last_pass = (r_pass == PW'(PASSES - 1));

  // Window test and bin index for the incoming sample of the current pixel.
  // Window width shrinks by NB bits per pass; pass 0 covers the full range.
  assign w_lo_cur = r_lo[r_pix];
  assign w_off    = data - w_lo_cur;
  assign w_win_sh = 32'(NP) - 32'(r_pass) * 32'(NB);
  assign w_bin_sh = 32'(NP) - (32'(r_pass) + 32'd1) * 32'(NB);
  assign w_in_win = (data >= w_lo_cur) && (({1'b0, w_off} >> w_win_sh) == '0);
  assign w_bin    = NB'(w_off >> w_bin_sh);
  assign w_addr   = AW'(32'(r_pix) * 32'(BINS) + 32'(w_bin));

  // The array read is combinational, so an accept hitting the same word on
  // the very next cycle already sees the previous increment: no bypass path
  // is needed to avoid losing counts.
  assign w_old_cnt = r_bvalid[w_addr] ? r_hist[w_addr] : '0;
  assign w_new_cnt = (w_old_cnt == CNT_MAX) ? CNT_MAX : w_old_cnt + CNT_W'(1);

  // Per-pixel window refinement and final result computed for UPDATE.
  for (genvar gi = 0; gi < PIXELS; gi++) begin : g_pix
    assign w_has_peak[gi] = (r_max[gi] != '0);
    assign w_lo_new[gi]   = w_has_peak[gi] ? r_lo[gi] + (NP'(r_peak[gi]) << w_bin_sh) : r_lo[gi];
    assign w_mask_new[gi] = r_mask[gi] & w_has_peak[gi];
    assign w_result_new[gi*NP +: NP] = w_mask_new[gi] ? w_lo_new[gi] : '0;
  end

  // Histogram read-modify-write: saturated count lands on the accept edge.
  always_ff @(posedge clk) begin
    if (w_accept && w_in_win) begin
      r_hist[w_addr] <= w_new_cnt;
    end
  end

  // Per-word valid bits stand in for clearing the whole histogram each pass.
  always_ff @(posedge clk) begin
    if (!res || r_state == S_UPDATE) begin
      r_bvalid <= '0;
    end else if (w_accept && w_in_win) begin
      r_bvalid[w_addr] <= 1'b1;
    end
  end

  // Capture the freshly written count so peak tracking runs one cycle later.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_pk_valid <= 1'b0;
      r_pk_pix   <= '0;
      r_pk_bin   <= '0;
      r_pk_cnt   <= '0;
    end else begin
      r_pk_valid <= w_accept && w_in_win;
      r_pk_pix   <= r_pix;
      r_pk_bin   <= w_bin;
      r_pk_cnt   <= w_new_cnt;
    end
  end

  // Peak tracker: strictly-greater update keeps the bin that got there first.
  always_ff @(posedge clk) begin
    if (!res || r_state == S_UPDATE) begin
      for (int p = 0; p < PIXELS; p++) begin
        r_max[p]  <= '0;
        r_peak[p] <= '0;
      end
    end else if (r_pk_valid && (r_pk_cnt > r_max[r_pk_pix])) begin
      r_max[r_pk_pix]  <= r_pk_cnt;
      r_peak[r_pk_pix] <= r_pk_bin;
    end
  end

`ifdef SIFH_PEAK_COUNT_EN
  logic [CNT_W*PIXELS-1:0] r_peak_cnt;
  logic [CNT_W*PIXELS-1:0] w_max_flat;

  for (genvar gi = 0; gi < PIXELS; gi++) begin : g_max_flat
    assign w_max_flat[gi*CNT_W +: CNT_W] = r_max[gi];
  end

  assign peak_cnt = r_peak_cnt;

  // Last-pass maxima, latched alongside the result.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_peak_cnt <= '0;
    end else if (r_state == S_UPDATE && w_last_pass) begin
      r_peak_cnt <= w_max_flat;
    end
  end
`endif

  // Frame sequencer: sample counters, pass stepping, window update and output.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_state        <= S_RUN;
      r_pass         <= '0;
      r_in_cnt       <= '0;
      r_pix          <= '0;
      r_acq          <= '0;
      r_in_ready     <= 1'b1;
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_result_mask  <= '0;
      r_mask         <= '1;
      for (int p = 0; p < PIXELS; p++) begin
        r_lo[p] <= '0;
      end
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            if (w_last_in) begin
              r_in_cnt <= '0;
              if (w_last_pix) begin
                r_pix <= '0;
                r_acq <= w_last_acq ? '0 : r_acq + QW'(1);
              end else begin
                r_pix <= r_pix + XW'(1);
              end
            end else begin
              r_in_cnt <= r_in_cnt + DW'(1);
            end
            if (w_pass_done) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          for (int p = 0; p < PIXELS; p++) begin
            r_lo[p] <= w_lo_new[p];
          end
          r_mask <= w_mask_new;
          if (w_last_pass) begin
            r_result       <= w_result_new;
            r_result_mask  <= w_mask_new;
            r_result_valid <= 1'b1;
            r_state        <= S_OUT;
          end else begin
            r_pass     <= r_pass + PW'(1);
            r_in_ready <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_OUT: begin
          r_pass     <= '0;
          r_mask     <= '1;
          r_in_ready <= 1'b1;
          r_state    <= S_RUN;
          for (int p = 0; p < PIXELS; p++) begin
            r_lo[p] <= '0;
          end
        end
        default: begin
          r_state    <= S_RUN;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sifh_zoom_histogrammer.sv
// Bench for sifh_zoom_histogrammer: default-parameter instance driven with
// whole frames, plus a tiny saturating instance (CNT_W=2, one pass).
module tb_sifh_zoom_histogrammer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        res;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] data;
  logic [1:0]  pass_idx;
  logic [47:0] result;
  logic [3:0]  result_mask;
  logic        result_valid;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [11:0] s_data;
  logic [0:0]  s_pass_idx;
  logic [11:0] s_result;
  logic [0:0]  s_result_mask;
  logic        s_result_valid;
`ifdef SIFH_PEAK_COUNT_EN
  logic [31:0] peak_cnt;
  logic [1:0]  s_peak_cnt;
`endif

  sifh_zoom_histogrammer u_dut (
    .clk          (clk),
    .res          (res),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data         (data),
    .pass_idx     (pass_idx),
    .result       (result),
    .result_mask  (result_mask),
    .result_valid (result_valid)
`ifdef SIFH_PEAK_COUNT_EN
    ,
    .peak_cnt     (peak_cnt)
`endif
  );

  sifh_zoom_histogrammer #(
    .CNT_W(2), .PASSES(1), .PIXELS(1), .DATA_PER_PIXEL(1), .ACQ_NUM(8)
  ) u_dut_sat (
    .clk          (clk),
    .res          (res),
    .in_valid     (s_in_valid),
    .in_ready     (s_in_ready),
    .data         (s_data),
    .pass_idx     (s_pass_idx),
    .result       (s_result),
    .result_mask  (s_result_mask),
    .result_valid (s_result_valid)
`ifdef SIFH_PEAK_COUNT_EN
    ,
    .peak_cnt     (s_peak_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [47:0] value;
    logic [3:0]  mask;
  } exp_t;

  exp_t        exp_q[$];
  int          stall_q[$];
  exp_t        mon_e;
  logic [11:0] fd [3][8][4][4];

  int cyc      = 0;
  int last_acc = 0;
  int low_cnt  = 0;
  bit mon_en   = 1'b0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: walk the samples in order exactly as the frame defines them.
  function automatic void model(output logic [47:0] r, output logic [3:0] m);
    int lo [4];
    int cnt [4][16];
    int mx [4];
    int pk [4];
    int sh, wsz, d, b;
    m = 4'hF;
    r = '0;
    for (int p = 0; p < 4; p++) lo[p] = 0;
    for (int k = 0; k < 3; k++) begin
      sh  = 12 - (k + 1) * 4;
      wsz = 1 << (12 - k * 4);
      for (int p = 0; p < 4; p++) begin
        mx[p] = 0;
        pk[p] = 0;
        for (int j = 0; j < 16; j++) cnt[p][j] = 0;
      end
      for (int a = 0; a < 8; a++)
        for (int p = 0; p < 4; p++)
          for (int i = 0; i < 4; i++) begin
            d = int'(fd[k][a][p][i]);
            if (d >= lo[p] && (d - lo[p]) < wsz) begin
              b = (d - lo[p]) >> sh;
              if (cnt[p][b] < 255) cnt[p][b]++;
              if (cnt[p][b] > mx[p]) begin
                mx[p] = cnt[p][b];
                pk[p] = b;
              end
            end
          end
      for (int p = 0; p < 4; p++) begin
        if (mx[p] > 0) lo[p] = lo[p] + (pk[p] << sh);
        else m[p] = 1'b0;
      end
    end
    for (int p = 0; p < 4; p++) r[p*12 +: 12] = m[p] ? 12'(lo[p]) : 12'h000;
  endfunction

  task automatic fill_const(input int scen);
    logic [11:0] v;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 8; a++)
        for (int p = 0; p < 4; p++)
          for (int i = 0; i < 4; i++) begin
            v = (p == 0) ? 12'hABC : 12'h123;
            if (scen == 1 && p == 1) v = (i == 3) ? 12'hF00 : 12'h500;
            if (scen == 1 && p == 2) v = (k == 0) ? 12'h7FF : 12'h100;
            fd[k][a][p][i] = v;
          end
  endtask

  task automatic fill_rand();
    int base [4];
    int t;
    for (int p = 0; p < 4; p++) base[p] = int'($urandom_range(0, 4095));
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 8; a++)
        for (int p = 0; p < 4; p++)
          for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 3) != 0) begin
              t = base[p] + int'($urandom_range(0, 15));
              if (t > 4095) t = 4095;
            end else begin
              t = int'($urandom_range(0, 4095));
            end
            fd[k][a][p][i] = 12'(t);
          end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check_value("ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // Drives one frame; abort_at >= 0 stops before that sample index.
  task automatic drive_frame(input bit gaps, input int abort_at);
    int cnt = 0;
    int g;
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      check_value($sformatf("pass_idx_%0d", k), 64'(pass_idx), 64'(k));
      for (int a = 0; a < 8; a++)
        for (int p = 0; p < 4; p++)
          for (int i = 0; i < 4; i++) begin
            g = 0;
            while (gaps && g < 6 && $urandom_range(0, 1) == 1) begin
              in_valid = 1'b0;
              @(posedge clk); #1;
              g++;
            end
            if (cnt == abort_at) begin
              in_valid = 1'b0;
              return;
            end
            wait_ready();
            in_valid = 1'b1;
            data     = fd[k][a][p][i];
            @(posedge clk); #1;
            cnt++;
          end
      in_valid = 1'b0;
      stall_q.push_back((k == 2) ? 3 : 2);
    end
  endtask

  task automatic push_exp(input logic [47:0] v, input logic [3:0] m);
    exp_t e;
    e.value = v;
    e.mask  = m;
    exp_q.push_back(e);
  endtask

  task automatic run_sat();
    int n = 0;
    check_value("sat_ready", 64'(s_in_ready), 64'd1);
    for (int a = 0; a < 8; a++) begin
      s_in_valid = 1'b1;
      s_data     = (a < 3) ? 12'h500 : 12'h200;
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    while (!s_result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_value("sat_latency", 64'(n), 64'd3);
    check_value("sat_result", 64'(s_result), 64'h500);
    check_value("sat_mask", 64'(s_result_mask), 64'd1);
`ifdef SIFH_PEAK_COUNT_EN
    check_value("sat_peak_cnt", 64'(s_peak_cnt), 64'd3);
`endif
    $display("sat frame result=0x%03h mask=%0b", s_result, s_result_mask);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) last_acc <= cyc;
  end

  // Output monitor: pops the scoreboard on result_valid, measures stalls.
  always @(negedge clk) begin
    if (mon_en) begin
      if (result_valid) begin
        check_value("rv_latency", 64'(cyc - last_acc), 64'd3);
        if (exp_q.size() == 0) begin
          check_value("rv_unexpected", 64'(result_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_value("result", 64'(result), 64'(mon_e.value));
          check_value("result_mask", 64'(result_mask), 64'(mon_e.mask));
          $display("frame result=0x%012h mask=0x%0h expected=0x%012h/0x%0h",
                   result, result_mask, mon_e.value, mon_e.mask);
        end
      end
      if (!in_ready) begin
        low_cnt <= low_cnt + 1;
      end else if (low_cnt != 0) begin
        if (stall_q.size() == 0) check_value("stall_unexpected", 64'(low_cnt), 64'd0);
        else check_value("stall_len", 64'(low_cnt), 64'(stall_q.pop_front()));
        low_cnt <= 0;
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [47:0] mv;
    logic [3:0]  mm;
    res        = 1'b0;
    in_valid   = 1'b0;
    data       = '0;
    s_in_valid = 1'b0;
    s_data     = '0;
    repeat (3) @(posedge clk);
    #1;
    res    = 1'b1;
    mon_en = 1'b1;
    check_value("rst_in_ready", 64'(in_ready), 64'd1);
    check_value("rst_result_valid", 64'(result_valid), 64'd0);
    check_value("rst_result", 64'(result), 64'd0);
    check_value("rst_result_mask", 64'(result_mask), 64'd0);
    check_value("rst_pass_idx", 64'(pass_idx), 64'd0);
    check_value("rst_sat_result", 64'(s_result), 64'd0);
`ifdef SIFH_PEAK_COUNT_EN
    check_value("rst_peak_cnt", 64'(peak_cnt), 64'd0);
`endif

    // Constant pixels
    fill_const(0);
    push_exp(48'h123123123ABC, 4'hF);
    drive_frame(1'b0, -1);

    // Out-of-window discard and lost-window mask clear
    fill_const(1);
    push_exp(48'h123000500ABC, 4'b1011);
    drive_frame(1'b0, -1);

    // Same stimulus as the first frame with random valid gaps
    fill_const(0);
    push_exp(48'h123123123ABC, 4'hF);
    drive_frame(1'b1, -1);

    // Reset midway through pass 1
    fill_rand();
    drive_frame(1'b0, 128 + 60);
    check_value("pre_abort_pass", 64'(pass_idx), 64'd1);
    res = 1'b0;
    @(posedge clk); #1;
    check_value("abort_pass_idx", 64'(pass_idx), 64'd0);
    check_value("abort_in_ready", 64'(in_ready), 64'd1);
    res = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Fresh random frames against the reference model
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      model(mv, mm);
      push_exp(mv, mm);
      drive_frame(r[0], -1);
    end

    run_sat();

    repeat (10) @(posedge clk);
    #1;
    check_value("sb_empty", 64'(exp_q.size()), 64'd0);
    check_value("stall_q_empty", 64'(stall_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
